// File: rtl/score_display_mux.sv
// score_display_mux: packed-BCD game score counter with saturation, session
// high score, and a time-multiplexed active-low 7-segment driver.
// Optional build macro SCORE_DISP_BLANK_LZ_EN blanks leading zero digits
// (digit 0 always shown); undefined, every digit is displayed.
module score_display_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    apple_colline,
  input  logic [3:0]              points_i,
  input  logic                    clear_i,
  input  logic                    show_high_i,
  output logic [4*NUM_DIGITS-1:0] score_bcd_o,
  output logic [4*NUM_DIGITS-1:0] high_bcd_o,
  output logic                    saturated_o,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int SW    = 4 * NUM_DIGITS;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic             apple_d1;
  logic             score_evt;
  logic [3:0]       pts;
  logic [SW-1:0]    sum_bcd;
  logic             add_ovf;
  logic [PRE_W-1:0] pre_cnt;
  logic [IDX_W-1:0] dig_idx;
  logic [SW-1:0]    disp_src;
  logic [3:0]       cur_digit;
  logic             blank;
  logic [NUM_DIGITS-1:0] an_next;

  assign score_evt   = apple_colline & ~apple_d1;
  assign saturated_o = (score_bcd_o == ALL_NINES);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Decimal ripple add of the event's points into digit 0; carry out of the top digit flags saturation.
  always_comb begin
    logic [4:0] dsum;
    logic       carry;
    pts     = (points_i > 4'd9) ? 4'd0 : points_i;
    sum_bcd = '0;
    carry   = 1'b0;
    dsum    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dsum = {1'b0, score_bcd_o[4*k +: 4]} + {4'd0, carry};
      if (k == 0) dsum = dsum + {1'b0, pts};
      if (dsum > 5'd9) begin
        sum_bcd[4*k +: 4] = 4'(dsum - 5'd10);
        carry             = 1'b1;
      end else begin
        sum_bcd[4*k +: 4] = dsum[3:0];
        carry             = 1'b0;
      end
    end
    add_ovf = carry;
  end

  // Edge detect, score update (clear beats an event) and high-score tracking.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      apple_d1    <= 1'b0;
      score_bcd_o <= '0;
      high_bcd_o  <= '0;
    end else begin
      apple_d1 <= apple_colline;
      if (clear_i) begin
        score_bcd_o <= '0;
      end else if (score_evt && !saturated_o) begin
        score_bcd_o <= add_ovf ? ALL_NINES : sum_bcd;
      end
      // Valid BCD orders the same as plain binary, so an unsigned compare suffices.
      if (score_bcd_o > high_bcd_o) high_bcd_o <= score_bcd_o;
    end
  end

  // Scan prescaler and digit index; the index advances once per SCAN_DIV clocks.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pre_cnt <= '0;
      dig_idx <= '0;
    end else if (pre_cnt == PRE_W'(SCAN_DIV - 1)) begin
      pre_cnt <= '0;
      dig_idx <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Select the digit being scanned, its anode pattern and whether it is a blanked leading zero.
  always_comb begin
    disp_src  = show_high_i ? high_bcd_o : score_bcd_o;
    cur_digit = disp_src[4*int'(dig_idx) +: 4];
    an_next   = '1;
    an_next[dig_idx] = 1'b0;
`ifdef SCORE_DISP_BLANK_LZ_EN
    blank = (dig_idx != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(dig_idx) && disp_src[4*k +: 4] != 4'd0) blank = 1'b0;
    end
`else
    blank = 1'b0;
`endif
  end

  // Segments and anodes are registered together so they always describe the same digit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      seg_o <= 7'b1111111;
      an_o  <= '1;
    end else begin
      seg_o <= blank ? 7'b1111111 : seg_decode(cur_digit);
      an_o  <= an_next;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Testbench for score_display_mux (NUM_DIGITS=4, SCAN_DIV=4).
module tb_score_display_mux;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        apple_colline;
  logic [3:0]  points_i;
  logic        clear_i;
  logic        show_high_i;
  logic [15:0] score_bcd_o;
  logic [15:0] high_bcd_o;
  logic        saturated_o;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;

  score_display_mux #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .apple_colline(apple_colline),
    .points_i(points_i), .clear_i(clear_i), .show_high_i(show_high_i),
    .score_bcd_o(score_bcd_o), .high_bcd_o(high_bcd_o), .saturated_o(saturated_o),
    .seg_o(seg_o), .an_o(an_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int score_m;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        apple;
    logic [3:0]  pts;
    logic        clr;
    logic [15:0] exp_score;
  } vec_t;
  vec_t vecs[16];

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000,
                         SB = 7'b1111111;
`ifdef SCORE_DISP_BLANK_LZ_EN
  localparam logic [6:0] SLZ = SB;
`else
  localparam logic [6:0] SLZ = S0;
`endif

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk_i);
    reset_ni = 1'b0; apple_colline = 1'b0; points_i = 4'd0;
    clear_i = 1'b0; show_high_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    score_m = 0;
  endtask

  // One event of p points: expectation queued at drive time, popped when the score is visible.
  task automatic pulse(input int p);
    apple_colline = 1'b1;
    points_i = 4'(p);
    score_m = (score_m + ((p > 9) ? 0 : p) > 9999) ? 9999 : score_m + ((p > 9) ? 0 : p);
    exp_q.push_back(to_bcd(score_m));
    @(negedge clk_i);
    check("pulse_score", score_bcd_o, exp_q.pop_front());
    apple_colline = 1'b0;
    @(negedge clk_i);
  endtask

  // Align to the start of digit 0 and check all four digits over a full scan.
  task automatic scan_check(input string name, input logic [27:0] segs);
    logic [3:0] prev;
    logic found;
    found = 1'b0;
    prev = an_o;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk_i);
      if (an_o == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = an_o;
    end
    check({name, "_sync"}, {31'd0, found}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        check({name, "_an"}, {28'd0, an_o}, {28'd0, ~(4'b0001 << i)});
        check({name, "_seg"}, {25'd0, seg_o}, {25'd0, segs[7*i +: 7]});
        @(negedge clk_i);
      end
    end
  endtask

  initial begin
    logic [15:0] high_m;
    logic [15:0] prev_score;

    vecs[0]  = '{1'b1, 4'd5,  1'b0, 16'h0005};
    vecs[1]  = '{1'b0, 4'd5,  1'b0, 16'h0005};
    vecs[2]  = '{1'b1, 4'd5,  1'b0, 16'h0010};
    vecs[3]  = '{1'b0, 4'd0,  1'b0, 16'h0010};
    vecs[4]  = '{1'b1, 4'd5,  1'b0, 16'h0015};
    vecs[5]  = '{1'b0, 4'd9,  1'b0, 16'h0015};
    vecs[6]  = '{1'b1, 4'd9,  1'b0, 16'h0024};
    vecs[7]  = '{1'b1, 4'd9,  1'b0, 16'h0024};
    vecs[8]  = '{1'b0, 4'd12, 1'b0, 16'h0024};
    vecs[9]  = '{1'b1, 4'd12, 1'b0, 16'h0024};
    vecs[10] = '{1'b0, 4'd8,  1'b0, 16'h0024};
    vecs[11] = '{1'b1, 4'd8,  1'b0, 16'h0032};
    vecs[12] = '{1'b0, 4'd0,  1'b0, 16'h0032};
    vecs[13] = '{1'b1, 4'd7,  1'b1, 16'h0000};
    vecs[14] = '{1'b0, 4'd0,  1'b0, 16'h0000};
    vecs[15] = '{1'b1, 4'd3,  1'b0, 16'h0003};

    reset_ni = 1'b0; apple_colline = 1'b0; points_i = 4'd0;
    clear_i = 1'b0; show_high_i = 1'b0; score_m = 0;
    repeat (2) @(negedge clk_i);
    check("rst_score", score_bcd_o, 16'h0000);
    check("rst_high", high_bcd_o, 16'h0000);
    check("rst_sat", saturated_o, 1'b0);
    check("rst_seg", seg_o, 7'b1111111);
    check("rst_an", an_o, 4'b1111);
    reset_ni = 1'b1;

    // table-driven vectors; high trails the score by one cycle
    high_m = '0;
    prev_score = '0;
    for (int i = 0; i < 16; i++) begin
      apple_colline = vecs[i].apple;
      points_i      = vecs[i].pts;
      clear_i       = vecs[i].clr;
      exp_q.push_back(vecs[i].exp_score);
      @(negedge clk_i);
      if (prev_score > high_m) high_m = prev_score;
      check($sformatf("vec%0d_score", i), score_bcd_o, exp_q.pop_front());
      check($sformatf("vec%0d_high", i), high_bcd_o, high_m);
      check($sformatf("vec%0d_sat", i), saturated_o, 1'b0);
      prev_score = vecs[i].exp_score;
    end
    clear_i = 1'b0;
    apple_colline = 1'b0;
    @(negedge clk_i);
    score_m = 3;

    // held-high level is a single event
    apple_colline = 1'b1;
    points_i = 4'd1;
    exp_q.push_back(to_bcd(score_m + 1));
    repeat (100) @(negedge clk_i);
    check("held_score", score_bcd_o, exp_q.pop_front());
    apple_colline = 1'b0;
    @(negedge clk_i);
    score_m = score_m + 1;

    // 1-0-1 edges each count
    pulse(2);
    pulse(2);
    check("fast_edges", score_bcd_o, 16'h0008);

    // saturation from 9995
    do_reset();
    for (int i = 0; i < 1110; i++) pulse(9);
    pulse(5);
    check("pre_sat", score_bcd_o, 16'h9995);
    check("pre_sat_flag", saturated_o, 1'b0);
    pulse(7);
    check("sat_flag", saturated_o, 1'b1);
    pulse(1);
    check("sat_hold", score_bcd_o, 16'h9999);
    @(negedge clk_i);
    check("sat_high", high_bcd_o, 16'h9999);

    // clear together with an event; high survives, shown via show_high_i
    do_reset();
    for (int i = 0; i < 4; i++) pulse(9);
    pulse(6);
    @(negedge clk_i);
    check("pre_clr_high", high_bcd_o, 16'h0042);
    apple_colline = 1'b1; points_i = 4'd3; clear_i = 1'b1;
    @(negedge clk_i);
    check("clr_score", score_bcd_o, 16'h0000);
    apple_colline = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    check("clr_high", high_bcd_o, 16'h0042);
    show_high_i = 1'b1;
    scan_check("show_high", {SLZ, SLZ, S4, S2});
    show_high_i = 1'b0;

    // scan of 1234
    do_reset();
    for (int i = 0; i < 137; i++) pulse(9);
    pulse(1);
    check("scan_val", score_bcd_o, 16'h1234);
    scan_check("scan1234", {S1, S2, S3, S4});

    // leading-zero handling on 0007, then async reset mid-scan
    do_reset();
    pulse(7);
    scan_check("scan0007", {SLZ, SLZ, SLZ, S7});
    @(negedge clk_i);
    @(negedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    check("async_an", an_o, 4'b1111);
    check("async_seg", seg_o, 7'b1111111);
    check("async_score", score_bcd_o, 16'h0000);
    check("async_high", high_bcd_o, 16'h0000);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_display_mux.md
# score_display_mux

Parametrised successor to the two-digit score display. It counts game-score events in packed BCD across `NUM_DIGITS` digits, adding a variable point value per event with saturation. It tracks a session high score and time-multiplexes the selected value onto one shared active-low 7-segment bus with per-digit anode enables. It sits between the snake game core (collision and new-game events) and the board's multiplexed 7-segment display.

## Interface
- `NUM_DIGITS`, default 4: number of BCD digits (2..8); score width is 4*NUM_DIGITS.
- `SCAN_DIV`, default 50000: clock cycles each digit is driven before advancing (>=2).
- `clk_i`  in  1  single clock; all state on its rising edge.
- `reset_ni`  in  1  reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
- `apple_colline`  in  1  level from game core; each rising edge is one scoring event.
- `points_i`  in  4  BCD points per event (0..9), sampled in the edge-detect cycle; values 10..15 treated as 0.
- `clear_i`  in  1  synchronous new-game clear of current score.
- `show_high_i`  in  1  0 = display current score, 1 = display high score.
- `score_bcd_o`  out  4*NUM_DIGITS  current score, packed BCD, digit 0 = LSBs.
- `high_bcd_o`  out  4*NUM_DIGITS  high score, packed BCD.
- `saturated_o`  out  1  high when score equals all-nines.
- `seg_o`  out  7  active-low segments {g,f,e,d,c,b,a}.
- `an_o`  out  NUM_DIGITS  active-low one-hot digit enable.

## Operation
- Edge detect: `apple_colline` registered once; event = `apple_colline & ~d1`. d1 resets to 0, so a level already high at reset release counts as an event in the first clock.
- Add: per-digit decimal ripple add of `points_i` into digit 0 with carry, done in one cycle. The result is valid BCD.
- Saturation: if the add would carry out of the top digit, score becomes all-nines. `saturated_o` = score is all-nines. Further events are ignored.
- Clear: `clear_i` sets score to 0 next cycle. When clear and an event occur in the same cycle, clear wins and the event is dropped.
- High score: each cycle, if `score_bcd_o > high_bcd_o` (unsigned BCD compare), high <= score. Only reset clears the high score; `clear_i` does not.
- Scan: prescaler counts 0..SCAN_DIV-1. On the terminal count, digit index advances 0→1→…→NUM_DIGITS-1→0.
- Display source = `show_high_i ? high : score`, sampled per scan cycle.
- Segment codes 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any other code gives 1111111.
- `seg_o` and `an_o` are registered together, so the enable and segments always belong to the same digit.

## Timing
- Reset values: score 0, high 0, `saturated_o` 0, d1 0, prescaler 0, index 0, `seg_o` 1111111, `an_o` all ones (display off until the first registered update one cycle after reset release).
- Event latency: rising edge seen in cycle N → `score_bcd_o` updated at the end of cycle N (visible in N+1).
- `high_bcd_o` follows at N+2.
- Display output registers update every clock from the current index and source, so a score change reaches `seg_o` no later than one cycle after the digit is selected.
- A held-high `apple_colline` produces exactly one event. Edges closer than 2 cycles apart (1-0-1) each count.
- Reset asserted mid-operation clears all state immediately, including the high score.

## Configuration
- `SCORE_DISP_BLANK_LZ_EN` defined: leading zeros are blanked. Digit k shows 1111111, with its anode still driven, when it and all higher digits are 0. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: all digits are always shown, including leading zeros.

## Test plan
- Reset, then 3 edges of `apple_colline` with `points_i`=5: score reaches 0x0015, `high_bcd_o` 0x0015 one cycle later, `saturated_o`=0.
- `apple_colline` held high 100 cycles with `points_i`=1: score increments exactly once.
- Score 0x9995, event with `points_i`=7: score 0x9999, `saturated_o`=1. A further event with `points_i`=1 leaves 0x9999.
- Score 0x0042, `clear_i` together with an event edge: score 0x0000, high stays 0x0042. `show_high_i`=1 displays 0042.
- `SCAN_DIV`=4, score 0x1234: `an_o` cycles 1110,1101,1011,0111 every 4 cycles with `seg_o` 0011001, 0110000, 0100100, 1111001. With the macro defined and score 0x0007, digits 1..3 show 1111111.
- Reset asserted mid-scan: `an_o` goes all ones and `seg_o` 1111111 immediately, without waiting for a clock edge.
